mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 255: maximum number of cycles spent waiting on the bus before a timeout (legal range 1..255).
REQ-002 SHALL use one clock; reset SHALL be asynchronous and active-high.
REQ-003 clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 mem_en  in  1  MEM-stage instruction is a load or store.
REQ-006 mem_we  in  1  1 = store, 0 = load.
REQ-007 mem_size  in  2  00 = byte, 01 = half, 10 = word; 11 is treated as word.
REQ-008 mem_sign  in  1  sign-extend a load result (1) or zero-extend it (0).
REQ-009 addr  in  32  byte address from the EX/MEM result.
REQ-010 wdata  in  32  store data, right-aligned.
REQ-011 rdata  out  32  aligned, extended load result that feeds the MEM/WB read-data input.
REQ-012 stall_m  out  1  holds the pipeline while an access is outstanding.
REQ-013 adel / ades  out  1 each  load / store address-alignment error.
REQ-014 bus_err  out  1  bus timeout flag; one-cycle pulse.
REQ-015 bus_req, bus_wr  out  1 each; bus_size  out  2; bus_addr  out  32; bus_wstrb  out  4; bus_wdata  out  32.
REQ-016 bus_addr_ok, bus_data_ok  in  1 each; bus_rdata  in  32.

Function
REQ-017 Alignment: misaligned = (half & addr[0]) | (word & addr[1:0]!=0); start = mem_en & ~misaligned.
REQ-018 adel SHALL be mem_en & misaligned & ~mem_we, combinational; ades SHALL be mem_en & misaligned & mem_we, combinational.
REQ-019 A misaligned access SHALL NOT raise bus_req and SHALL NOT raise stall_m.
REQ-020 FSM states SHALL be IDLE, ADDR, DATA and DONE.
REQ-021 IDLE: go to DATA if start & bus_addr_ok; go to ADDR if start & ~bus_addr_ok; otherwise stay in IDLE.
REQ-022 ADDR: go to DATA on bus_addr_ok.
REQ-023 DATA: go to DONE on bus_data_ok, capturing bus_rdata into a register.
REQ-024 DONE: go to IDLE unconditionally after one cycle.
REQ-025 bus_req SHALL be (IDLE & start) | ADDR.
REQ-026 While bus_req is high, bus_addr, bus_wr, bus_size, bus_wstrb and bus_wdata SHALL stay constant until bus_addr_ok.
REQ-027 The address handshake completes in the cycle where bus_req & bus_addr_ok are both 1.
REQ-028 stall_m SHALL be start & (state != DONE).
REQ-029 Minimum latency: addr_ok in the first cycle plus data_ok in the next cycle gives 2 stall cycles, with stall_m low in the third cycle.
REQ-030 bus_addr = addr; bus_wr = mem_we; bus_size = mem_size.
REQ-031 bus_wstrb for a byte store SHALL be 4'b0001 << addr[1:0].
REQ-032 bus_wstrb for a half store SHALL be addr[1] ? 1100 : 0011.
REQ-033 bus_wstrb for a word store SHALL be 1111; for any load it SHALL be 0000.
REQ-034 bus_wdata SHALL be {4{wdata[7:0]}} for byte, {2{wdata[15:0]}} for half, and wdata for word.
REQ-035 At the request, addr[1:0], size and sign SHALL be registered.
REQ-036 In DONE, rdata SHALL select the captured lane (byte at offset*8, half at addr[1]*16) and extend it per mem_sign.
REQ-037 rdata SHALL be 0 for stores and 0 in every state other than DONE.
REQ-038 Timeout: an 8-bit counter SHALL clear when leaving IDLE and increment each cycle in ADDR or DATA.
REQ-039 When the counter reaches MAX_WAIT without completion, the FSM SHALL go to DONE with bus_err = 1 for that DONE cycle and rdata = 0.
REQ-040 bus_data_ok seen in IDLE, ADDR or DONE SHALL be ignored.
REQ-041 bus_addr_ok is only sampled while bus_req is high.
REQ-042 If mem_en falls (flush) after a request is issued, the transaction SHALL still complete through DONE and its result SHALL be dropped.
REQ-043 A new start SHALL only be accepted from IDLE.
REQ-044 Back-to-back accesses SHALL be spaced by the DONE cycle.

Reset
REQ-045 rst SHALL force the FSM to IDLE and clear the counter, the captured data and the registered lane/size/sign asynchronously.
REQ-046 Under reset: rdata = 0, bus_err = 0, bus_req = 0, and stall_m = 0 regardless of mem_en.
REQ-047 A transaction outstanding when reset is asserted SHALL be abandoned; a later bus_data_ok SHALL be ignored.

Verification
REQ-048 lw addr 0x100, addr_ok in cycle 0, data_ok in cycle 1 with bus_rdata 0x87654321 -> stall_m high for 2 cycles; in DONE rdata = 0x87654321.
REQ-049 lb addr 0x103, bus_rdata 0x80123456 -> rdata 0xFFFFFF80; same access as lbu -> rdata 0x00000080.
REQ-050 sh addr 0x102, wdata 0x0000BEEF -> bus_wr 1, bus_wstrb 1100, bus_wdata 0xBEEFBEEF; rdata stays 0.
REQ-051 lw addr 0x101 -> adel 1, bus_req 0, stall_m 0; sw addr 0x102 -> ades 1.
REQ-052 MAX_WAIT = 4, bus_addr_ok held low -> bus_req high for 4 cycles, then DONE with bus_err = 1 for 1 cycle, stall_m = 0 in that cycle, rdata = 0.
REQ-053 rst pulsed while in DATA -> all outputs at reset values immediately; a later data_ok is ignored; the next lw completes normally.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit
//
// MEM-stage load/store unit sitting between the pipeline and a split
// address/data handshake bus. Checks alignment, issues one bus access per
// aligned load/store, stalls the pipeline until the access finishes, and
// returns an aligned, sign/zero-extended load result during the DONE cycle.
// A wait counter abandons accesses that take too long and flags bus_err.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   mem_en, mem_we            access request, 1 = store / 0 = load
//   mem_size, mem_sign        00 byte, 01 half, 1x word; load sign-extension
//   addr, wdata               byte address, right-aligned store data
//   rdata                     extended load result (valid in DONE only)
//   stall_m                   pipeline hold while an access is outstanding
//   adel, ades                load / store misalignment (combinational)
//   bus_err                   one-cycle timeout pulse (in DONE)
//   bus_req, bus_wr           bus request and direction
//   bus_size, bus_addr        access size and byte address
//   bus_wstrb, bus_wdata      byte-lane strobes and lane-replicated data
//   bus_addr_ok, bus_data_ok  address accept / data complete from the bus
//   bus_rdata                 bus read data (full word, unaligned lanes)

module mem_access_unit #(
  parameter int MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_en,
  input  logic        mem_we,
  input  logic [1:0]  mem_size,
  input  logic        mem_sign,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall_m,
  output logic        adel,
  output logic        ades,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ADDR = 2'b01,
    DATA = 2'b10,
    DONE = 2'b11
  } stateType;

  // The request cycle itself counts as the first of the MAX_WAIT cycles, and
  // the counter starts at zero in the first ADDR/DATA cycle, so the last
  // allowed wait cycle is the one where the counter equals MAX_WAIT-2.
  localparam logic [7:0] WaitLimit = 8'((MAX_WAIT >= 2) ? (MAX_WAIT - 2) : 0);

  stateType    state;
  logic [7:0]  waitCnt;
  logic [31:0] addrQ;
  logic        weQ;
  logic [1:0]  sizeQ;
  logic        signQ;
  logic [31:0] wdataQ;
  logic [31:0] dataQ;
  logic        errQ;
  logic        dropQ;

  logic        isHalf;
  logic        isWord;
  logic        misaligned;
  logic        start;
  logic        waitExpired;
  logic        resultValid;

  logic [31:0] reqAddr;
  logic [31:0] reqWdata;
  logic        reqWe;
  logic [1:0]  reqSize;

  logic [7:0]  laneByte;
  logic [15:0] laneHalf;

  // Size 11 is handled as a word everywhere, so only bit 1 matters for word.
  assign isHalf     = (mem_size == 2'b01);
  assign isWord     = mem_size[1];
  assign misaligned = (isHalf & addr[0]) | (isWord & (addr[1:0] != 2'b00));
  assign start      = mem_en & ~misaligned;

  assign adel = mem_en & misaligned & ~mem_we;
  assign ades = mem_en & misaligned & mem_we;

  assign waitExpired = (waitCnt == WaitLimit);

  // Both handshake-facing outputs are forced low during reset even though
  // start is derived combinationally from the pipeline inputs.
  assign bus_req = ~rst & (((state == IDLE) & start) | (state == ADDR));
  assign stall_m = ~rst & start & (state != DONE);
  assign bus_err = (state == DONE) & errQ;

  // In IDLE the request is presented straight from the pipeline; once it
  // has been issued the registered copy is used, so the bus sees a stable
  // request until the address handshake even if the pipeline inputs move.
  assign reqAddr  = (state == IDLE) ? addr     : addrQ;
  assign reqWdata = (state == IDLE) ? wdata    : wdataQ;
  assign reqWe    = (state == IDLE) ? mem_we   : weQ;
  assign reqSize  = (state == IDLE) ? mem_size : sizeQ;

  assign bus_addr = reqAddr;
  assign bus_wr   = reqWe;
  assign bus_size = reqSize;

  always_comb begin
    bus_wstrb = 4'b0000;
    if (reqWe) begin
      case (reqSize)
        2'b00:   bus_wstrb = 4'b0001 << reqAddr[1:0];
        2'b01:   bus_wstrb = reqAddr[1] ? 4'b1100 : 4'b0011;
        default: bus_wstrb = 4'b1111;
      endcase
    end
  end

  // Store data is replicated across all lanes; the strobes pick the lane.
  always_comb begin
    case (reqSize)
      2'b00:   bus_wdata = {4{reqWdata[7:0]}};
      2'b01:   bus_wdata = {2{reqWdata[15:0]}};
      default: bus_wdata = reqWdata;
    endcase
  end

  // A result is only delivered for a load that completed normally and was
  // not flushed while outstanding.
  assign resultValid = (state == DONE) & ~errQ & ~weQ & ~dropQ & mem_en;

  always_comb begin
    laneByte = 8'h00;
    case (addrQ[1:0])
      2'b00:   laneByte = dataQ[7:0];
      2'b01:   laneByte = dataQ[15:8];
      2'b10:   laneByte = dataQ[23:16];
      default: laneByte = dataQ[31:24];
    endcase
  end

  assign laneHalf = addrQ[1] ? dataQ[31:16] : dataQ[15:0];

  always_comb begin
    rdata = 32'h0000_0000;
    if (resultValid) begin
      case (sizeQ)
        2'b00:   rdata = signQ ? {{24{laneByte[7]}}, laneByte} : {24'h000000, laneByte};
        2'b01:   rdata = signQ ? {{16{laneHalf[15]}}, laneHalf} : {16'h0000, laneHalf};
        default: rdata = dataQ;
      endcase
    end
  end

  // Access sequencer. In ADDR a timeout wins over a late bus_addr_ok so the
  // wait bound is never exceeded; in DATA an arriving bus_data_ok wins over
  // the timeout because the data is already there.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      waitCnt <= 8'h00;
      addrQ   <= 32'h0000_0000;
      weQ     <= 1'b0;
      sizeQ   <= 2'b00;
      signQ   <= 1'b0;
      wdataQ  <= 32'h0000_0000;
      dataQ   <= 32'h0000_0000;
      errQ    <= 1'b0;
      dropQ   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          errQ <= 1'b0;
          if (start) begin
            addrQ   <= addr;
            weQ     <= mem_we;
            sizeQ   <= mem_size;
            signQ   <= mem_sign;
            wdataQ  <= wdata;
            dropQ   <= 1'b0;
            waitCnt <= 8'h00;
            state   <= bus_addr_ok ? DATA : ADDR;
          end
        end
        ADDR: begin
          waitCnt <= waitCnt + 8'd1;
          if (!mem_en) begin
            dropQ <= 1'b1;
          end
          if (waitExpired) begin
            errQ  <= 1'b1;
            state <= DONE;
          end else if (bus_addr_ok) begin
            state <= DATA;
          end
        end
        DATA: begin
          waitCnt <= waitCnt + 8'd1;
          if (!mem_en) begin
            dropQ <= 1'b1;
          end
          if (bus_data_ok) begin
            dataQ <= bus_rdata;
            state <= DONE;
          end else if (waitExpired) begin
            errQ  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          errQ  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit
//
// Self-checking bench for mem_access_unit (MAX_WAIT = 4). A table of
// hand-computed load/store vectors and a batch of random vectors are run
// through one task that drives the bus handshake with a chosen address and
// data latency and compares every cycle against a timing/data model derived
// from the access rules. Hand-written sequences cover reset and flush.

module tb_mem_access_unit;

  localparam int MaxWait = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_en;
  logic        mem_we;
  logic [1:0]  mem_size;
  logic        mem_sign;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall_m;
  logic        adel;
  logic        ades;
  logic        bus_err;
  logic        bus_req;
  logic        bus_wr;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        bus_addr_ok;
  logic        bus_data_ok;
  logic [31:0] bus_rdata;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sign;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] busRdata;
    int          addrLat;
    int          dataLat;
    logic [31:0] expRdata;
    logic [3:0]  expWstrb;
    logic [31:0] expWdata;
    logic        expAdel;
    logic        expAdes;
  } vecType;

  vecType vecs[$];

  always #5 clk = ~clk;

  mem_access_unit #(.MAX_WAIT(MaxWait)) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_size    (mem_size),
    .mem_sign    (mem_sign),
    .addr        (addr),
    .wdata       (wdata),
    .rdata       (rdata),
    .stall_m     (stall_m),
    .adel        (adel),
    .ades        (ades),
    .bus_err     (bus_err),
    .bus_req     (bus_req),
    .bus_wr      (bus_wr),
    .bus_size    (bus_size),
    .bus_addr    (bus_addr),
    .bus_wstrb   (bus_wstrb),
    .bus_wdata   (bus_wdata),
    .bus_addr_ok (bus_addr_ok),
    .bus_data_ok (bus_data_ok),
    .bus_rdata   (bus_rdata)
  );

  // Reference rules, written arithmetically from the access definition.
  function automatic bit misalignedRef(input logic [1:0] size, input logic [31:0] a);
    return (size == 2'd1 && (a % 2) != 0) || (size >= 2'd2 && (a % 4) != 0);
  endfunction

  function automatic logic [31:0] loadRef(input logic [1:0] size, input logic sign,
                                          input logic [31:0] a, input logic [31:0] word);
    longint w;
    longint off;
    longint v;
    logic [63:0] r;
    w   = longint'(word);
    off = longint'(a % 4);
    if (size == 2'd0) begin
      v = (w / (longint'(1) << (off * 8))) % 256;
      if (sign && v >= 128) v = v - 256;
    end else if (size == 2'd1) begin
      v = (w / (longint'(1) << ((off / 2) * 16))) % 65536;
      if (sign && v >= 32768) v = v - 65536;
    end else begin
      v = w;
    end
    r = 64'(v);
    return r[31:0];
  endfunction

  function automatic logic [3:0] strobeRef(input logic we, input logic [1:0] size,
                                           input logic [31:0] a);
    if (!we) return 4'b0000;
    if (size == 2'd0) return 4'(1 << (a % 4));
    if (size == 2'd1) return ((a % 4) >= 2) ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] wdataRef(input logic [1:0] size, input logic [31:0] wd);
    if (size == 2'd0) return 32'((wd % 256) * 32'h0101_0101);
    if (size == 2'd1) return 32'((wd % 65536) * 32'h0001_0001);
    return wd;
  endfunction

  function automatic vecType mk(input logic we, input logic [1:0] size, input logic sign,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] brd, input int al, input int dl,
                                input logic [31:0] expRd, input logic [3:0] expStrb,
                                input logic [31:0] expWd, input logic expAdel,
                                input logic expAdes);
    vecType t;
    t.we = we; t.size = size; t.sign = sign; t.addr = a; t.wdata = wd;
    t.busRdata = brd; t.addrLat = al; t.dataLat = dl; t.expRdata = expRd;
    t.expWstrb = expStrb; t.expWdata = expWd; t.expAdel = expAdel; t.expAdes = expAdes;
    return t;
  endfunction

  task automatic checkOutput(input string name, input logic [95:0] actual,
                             input logic [95:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic driveRequest(input vecType t);
    mem_en   = 1'b1;
    mem_we   = t.we;
    mem_size = t.size;
    mem_sign = t.sign;
    addr     = t.addr;
    wdata    = t.wdata;
  endtask

  task automatic idleCycle(input string tag);
    @(negedge clk);
    mem_en      = 1'b0;
    bus_addr_ok = 1'($urandom_range(1));
    bus_data_ok = 1'($urandom_range(1));
    bus_rdata   = $urandom();
    #1;
    checkOutput({tag, " idle"}, {bus_req, stall_m, bus_err, rdata}, 96'h0);
  endtask

  // Runs one access. Bus timing model: the request is cycle 0, bus_addr_ok
  // arrives in cycle addrLat and bus_data_ok in cycle addrLat+dataLat. The
  // access succeeds if data arrives within the first MaxWait cycles; either
  // way DONE follows the last bus-facing cycle.
  task automatic applyStimulus(input vecType t, input string tag);
    int a;
    int d;
    int doneCyc;
    int reqLast;
    bit ok;
    bit expReq;
    bit expStall;
    bit expErr;
    logic [31:0] expRd;
    if (misalignedRef(t.size, t.addr)) begin
      @(negedge clk);
      driveRequest(t);
      bus_addr_ok = 1'($urandom_range(1));
      bus_data_ok = 1'($urandom_range(1));
      #1;
      checkOutput({tag, " align"}, {adel, ades, bus_req, stall_m},
                  {t.expAdel, t.expAdes, 2'b00});
      @(negedge clk);
      #1;
      checkOutput({tag, " noaccess"}, {bus_req, stall_m, bus_err, rdata}, 96'h0);
      idleCycle(tag);
    end else begin
      a = t.addrLat;
      d = t.dataLat;
      ok = (a + d <= MaxWait - 1);
      doneCyc = ok ? (a + d + 1) : MaxWait;
      reqLast = (a < MaxWait - 1) ? a : (MaxWait - 1);
      for (int c = 0; c <= doneCyc; c++) begin
        @(negedge clk);
        driveRequest(t);
        bus_addr_ok = (c == a) || (c > a && $urandom_range(1) == 1);
        bus_data_ok = (c == a + d) || ((c <= a || c == doneCyc) && $urandom_range(1) == 1);
        bus_rdata   = (c == a + d) ? t.busRdata : $urandom();
        #1;
        expReq   = (c <= reqLast);
        expStall = (c < doneCyc);
        expErr   = !ok && (c == doneCyc);
        expRd    = (ok && c == doneCyc) ? t.expRdata : 32'h0;
        checkOutput($sformatf("%s c%0d req/stall/err/rdata", tag, c),
                    {bus_req, stall_m, bus_err, rdata},
                    {expReq, expStall, expErr, expRd});
        if (c <= reqLast) begin
          checkOutput($sformatf("%s c%0d busfields", tag, c),
                      {bus_addr, bus_wr, bus_size, bus_wstrb, bus_wdata, adel, ades},
                      {t.addr, t.we, t.size, t.expWstrb, t.expWdata, 2'b00});
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecType t;

    // Hand-computed vectors: we, size, sign, addr, wdata, busRdata,
    // addrLat, dataLat, rdata, wstrb, bus_wdata, adel, ades.
    vecs.push_back(mk(0, 2'd2, 0, 32'h100, 32'h0, 32'h87654321, 0, 1, 32'h87654321, 4'h0, 32'h0, 0, 0));
    vecs.push_back(mk(0, 2'd0, 1, 32'h103, 32'h0, 32'h80123456, 0, 1, 32'hFFFFFF80, 4'h0, 32'h0, 0, 0));
    vecs.push_back(mk(0, 2'd0, 0, 32'h103, 32'h0, 32'h80123456, 0, 1, 32'h00000080, 4'h0, 32'h0, 0, 0));
    vecs.push_back(mk(1, 2'd1, 0, 32'h102, 32'h0000BEEF, 32'hDEADDEAD, 0, 1, 32'h0, 4'b1100, 32'hBEEFBEEF, 0, 0));
    vecs.push_back(mk(0, 2'd1, 1, 32'h102, 32'h0, 32'h80017FFF, 1, 1, 32'hFFFF8001, 4'h0, 32'h0, 0, 0));
    vecs.push_back(mk(0, 2'd1, 0, 32'h102, 32'h0, 32'h80017FFF, 0, 2, 32'h00008001, 4'h0, 32'h0, 0, 0));
    vecs.push_back(mk(0, 2'd1, 1, 32'h100, 32'h0, 32'h80018FFF, 1, 2, 32'hFFFF8FFF, 4'h0, 32'h0, 0, 0));
    vecs.push_back(mk(0, 2'd0, 1, 32'h101, 32'h0, 32'h11AA2233, 0, 1, 32'h00000022, 4'h0, 32'h0, 0, 0));
    vecs.push_back(mk(0, 2'd0, 0, 32'h102, 32'h0, 32'h11AA2233, 2, 1, 32'h000000AA, 4'h0, 32'h0, 0, 0));
    vecs.push_back(mk(1, 2'd0, 0, 32'h101, 32'h12345678, 32'h0, 2, 1, 32'h0, 4'b0010, 32'h78787878, 0, 0));
    vecs.push_back(mk(1, 2'd0, 0, 32'h103, 32'h000000AB, 32'h0, 0, 1, 32'h0, 4'b1000, 32'hABABABAB, 0, 0));
    vecs.push_back(mk(1, 2'd2, 0, 32'h104, 32'hCAFEF00D, 32'h0, 0, 3, 32'h0, 4'b1111, 32'hCAFEF00D, 0, 0));
    vecs.push_back(mk(0, 2'd3, 1, 32'h108, 32'h0, 32'h0F0F0F0F, 1, 1, 32'h0F0F0F0F, 4'h0, 32'h0, 0, 0));
    vecs.push_back(mk(0, 2'd2, 0, 32'h10C, 32'h0, 32'h12345678, 99, 1, 32'h0, 4'h0, 32'h0, 0, 0));
    vecs.push_back(mk(0, 2'd2, 0, 32'h114, 32'h0, 32'h12345678, 3, 1, 32'h0, 4'h0, 32'h0, 0, 0));
    vecs.push_back(mk(0, 2'd2, 0, 32'h110, 32'h0, 32'h12345678, 0, 9, 32'h0, 4'h0, 32'h0, 0, 0));
    vecs.push_back(mk(0, 2'd2, 0, 32'h101, 32'h0, 32'h0, 0, 1, 32'h0, 4'h0, 32'h0, 1, 0));
    vecs.push_back(mk(1, 2'd2, 0, 32'h102, 32'h0, 32'h0, 0, 1, 32'h0, 4'h0, 32'h0, 0, 1));
    vecs.push_back(mk(0, 2'd1, 1, 32'h103, 32'h0, 32'h0, 0, 1, 32'h0, 4'h0, 32'h0, 1, 0));
    vecs.push_back(mk(1, 2'd1, 0, 32'h101, 32'h0, 32'h0, 0, 1, 32'h0, 4'h0, 32'h0, 0, 1));
    vecs.push_back(mk(0, 2'd3, 0, 32'h102, 32'h0, 32'h0, 0, 1, 32'h0, 4'h0, 32'h0, 1, 0));

    rst = 1'b0; mem_en = 1'b1; mem_we = 1'b0; mem_size = 2'd2; mem_sign = 1'b0;
    addr = 32'h100; wdata = 32'h0; bus_addr_ok = 1'b1; bus_data_ok = 1'b0; bus_rdata = 32'h0;
    #1 rst = 1'b1;
    #1;
    checkOutput("reset outputs", {bus_req, stall_m, bus_err, rdata}, 96'h0);
    @(negedge clk);
    rst = 1'b0;
    mem_en = 1'b0;
    bus_addr_ok = 1'b0;

    $display("[TB] table vectors");
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
    end

    $display("[TB] flush while outstanding");
    @(negedge clk);
    mem_en = 1'b1; mem_we = 1'b0; mem_size = 2'd2; mem_sign = 1'b0; addr = 32'h300;
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
    #1 checkOutput("flush c0", {bus_req, stall_m}, 96'b11);
    @(negedge clk);
    mem_en = 1'b0; bus_addr_ok = 1'b1;
    #1 checkOutput("flush c1", {bus_req, stall_m}, 96'b10);
    @(negedge clk);
    bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'hAAAA5555;
    #1 checkOutput("flush c2", {bus_req, stall_m}, 96'b00);
    @(negedge clk);
    mem_en = 1'b1; bus_data_ok = 1'b0;
    #1 checkOutput("flush done dropped", {bus_req, stall_m, bus_err, rdata}, 96'h0);
    applyStimulus(vecs[0], "after flush");

    $display("[TB] reset while in DATA");
    @(negedge clk);
    mem_en = 1'b1; mem_we = 1'b0; mem_size = 2'd2; addr = 32'h200;
    bus_addr_ok = 1'b1; bus_data_ok = 1'b0;
    #1 checkOutput("rst seq c0", {bus_req, stall_m}, 96'b11);
    @(negedge clk);
    bus_addr_ok = 1'b0;
    #1 checkOutput("rst seq c1", {bus_req, stall_m}, 96'b01);
    #1 rst = 1'b1;
    #1 checkOutput("rst immediate", {bus_req, stall_m, bus_err, rdata}, 96'h0);
    @(negedge clk);
    rst = 1'b0; mem_en = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h5A5A5A5A;
    #1 checkOutput("rst late data_ok", {bus_req, stall_m, bus_err, rdata}, 96'h0);
    applyStimulus(vecs[0], "after reset");

    $display("[TB] random vectors");
    for (int i = 0; i < 40; i++) begin
      t.we     = 1'($urandom_range(1));
      t.size   = 2'($urandom_range(3));
      t.sign   = 1'($urandom_range(1));
      t.addr   = $urandom();
      if ($urandom_range(3) != 0) begin
        if (t.size == 2'd1) t.addr = t.addr - (t.addr % 2);
        else if (t.size >= 2'd2) t.addr = t.addr - (t.addr % 4);
      end
      t.wdata    = $urandom();
      t.busRdata = $urandom();
      t.addrLat  = ($urandom_range(7) == 0) ? 5 : $urandom_range(0, 2);
      t.dataLat  = ($urandom_range(7) == 0) ? 4 : $urandom_range(1, 2);
      t.expRdata = t.we ? 32'h0 : loadRef(t.size, t.sign, t.addr, t.busRdata);
      t.expWstrb = strobeRef(t.we, t.size, t.addr);
      t.expWdata = wdataRef(t.size, t.wdata);
      t.expAdel  = misalignedRef(t.size, t.addr) && !t.we;
      t.expAdes  = misalignedRef(t.size, t.addr) && t.we;
      applyStimulus(t, $sformatf("rnd%0d", i));
      if ($urandom_range(3) == 0) idleCycle($sformatf("rnd%0d", i));
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
